// File: rtl/if_id_register_pkg.sv
// Constants and field-action decoding shared by the pipeline registers.
// Used by if_id_register (optional Valid_Out enabled with IF_ID_VALID_EN).
package if_id_register_pkg;

    localparam int INSTR_WIDTH = 16;
    localparam logic [INSTR_WIDTH-1:0] NOP_ENCODING = '0;

    typedef enum logic [1:0] {
        FIELD_LOAD  = 2'd0,
        FIELD_HOLD  = 2'd1,
        FIELD_CLEAR = 2'd2
    } field_action_e;

    // Reset and flush both produce a bubble, so they collapse into one clear action.
    function automatic field_action_e decode_action(
        input logic rst,
        input logic flush,
        input logic stall
    );
        if (rst || flush) begin
            return FIELD_CLEAR;
        end
        if (stall) begin
            return FIELD_HOLD;
        end
        return FIELD_LOAD;
    endfunction

endpackage

// File: rtl/if_id_register_pipe_field_reg.sv
// One field of a pipeline register: synchronous clear to a fixed value,
// otherwise load when enabled and hold when not.
module pipe_field_reg #(
    parameter int               Width      = 1,
    parameter logic [Width-1:0] ClearValue = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg <= ClearValue;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register: RST > Flush > Stall > load, every field registered.
// Define IF_ID_VALID_EN to add the Valid_Out flag.
module if_id_register
    import if_id_register_pkg::*;
#(
    parameter int                    InstrWidth = INSTR_WIDTH,
    parameter logic [InstrWidth-1:0] NOP_INSTR  = InstrWidth'(NOP_ENCODING)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [InstrWidth-1:0] Instruction_In,
    input  logic [InstrWidth-1:0] PC_In,
    input  logic                  Branch_Taken_In,
    output logic [InstrWidth-1:0] Instruction_Out,
    output logic [InstrWidth-1:0] PC_Out,
`ifdef IF_ID_VALID_EN
    output logic                  Valid_Out,
`endif
    output logic                  Branch_Taken_Out
);

    field_action_e action;
    logic          field_clr;
    logic          field_en;

    assign action    = decode_action(RST, Flush, Stall);
    assign field_clr = (action == FIELD_CLEAR);
    assign field_en  = (action == FIELD_LOAD);

    // All fields share one clear/enable pair so they can never update partially.
    pipe_field_reg #(
        .Width      (InstrWidth),
        .ClearValue (NOP_INSTR)
    ) u_instr_reg (
        .clk (CLK),
        .clr (field_clr),
        .en  (field_en),
        .d   (Instruction_In),
        .q   (Instruction_Out)
    );

    pipe_field_reg #(
        .Width      (InstrWidth),
        .ClearValue ('0)
    ) u_pc_reg (
        .clk (CLK),
        .clr (field_clr),
        .en  (field_en),
        .d   (PC_In),
        .q   (PC_Out)
    );

    pipe_field_reg #(
        .Width      (1),
        .ClearValue (1'b0)
    ) u_branch_reg (
        .clk (CLK),
        .clr (field_clr),
        .en  (field_en),
        .d   (Branch_Taken_In),
        .q   (Branch_Taken_Out)
    );

`ifdef IF_ID_VALID_EN
    pipe_field_reg #(
        .Width      (1),
        .ClearValue (1'b0)
    ) u_valid_reg (
        .clk (CLK),
        .clr (field_clr),
        .en  (field_en),
        .d   (1'b1),
        .q   (Valid_Out)
    );
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Self-checking bench for if_id_register: directed scenarios plus random
// traffic compared against a behavioural model of the stage register.
module tb_if_id_register;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [15:0] Instruction_In = '0;
    logic [15:0] PC_In = '0;
    logic        Branch_Taken_In = 1'b0;
    logic [15:0] Instruction_Out;
    logic [15:0] PC_Out;
    logic        Branch_Taken_Out;
`ifdef IF_ID_VALID_EN
    logic        Valid_Out;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model of what ID should see after each edge.
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic        m_bt;
    logic        m_valid;

    if_id_register dut (
        .CLK              (CLK),
        .RST              (RST),
        .Stall            (Stall),
        .Flush            (Flush),
        .Instruction_In   (Instruction_In),
        .PC_In            (PC_In),
        .Branch_Taken_In  (Branch_Taken_In),
        .Instruction_Out  (Instruction_Out),
        .PC_Out           (PC_Out),
`ifdef IF_ID_VALID_EN
        .Valid_Out        (Valid_Out),
`endif
        .Branch_Taken_Out (Branch_Taken_Out)
    );

    always #5 CLK = ~CLK;

    // Drive inputs on the falling edge, clock once, update the model, sample 1 ns later.
    task automatic step(input logic rst, input logic flush, input logic stall,
                        input logic [15:0] instr, input logic [15:0] pc, input logic bt);
        @(negedge CLK);
        RST = rst;
        Flush = flush;
        Stall = stall;
        Instruction_In = instr;
        PC_In = pc;
        Branch_Taken_In = bt;
        @(posedge CLK);
        if (rst || flush) begin
            m_instr = 16'd0;
            m_pc = 16'd0;
            m_bt = 1'b0;
            m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = instr;
            m_pc = pc;
            m_bt = bt;
            m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1234, 1'b1);
        checks++;
        if (Instruction_Out !== 16'd0 || PC_Out !== 16'd0 || Branch_Taken_Out !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %0d/%0d/%0d expected 0/0/0",
                     Instruction_Out, PC_Out, Branch_Taken_Out);
        end
`ifdef IF_ID_VALID_EN
        checks++;
        if (Valid_Out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b expected 0", Valid_Out);
        end
`endif
        $display("reset: out %0d/%0d/%0d", Instruction_Out, PC_Out, Branch_Taken_Out);
    endtask

    task automatic test_load();
        step(1'b0, 1'b0, 1'b0, 16'd36, 16'd54, 1'b1);
        checks++;
        if (Instruction_Out !== 16'd36 || PC_Out !== 16'd54 || Branch_Taken_Out !== 1'b1) begin
            errors++;
            $display("FAIL load: got %0d/%0d/%0d expected 36/54/1",
                     Instruction_Out, PC_Out, Branch_Taken_Out);
        end
`ifdef IF_ID_VALID_EN
        checks++;
        if (Valid_Out !== 1'b1) begin
            errors++;
            $display("FAIL load_valid: got %0b expected 1", Valid_Out);
        end
`endif
        $display("load: out %0d/%0d/%0d", Instruction_Out, PC_Out, Branch_Taken_Out);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'd25, 16'd78, 1'b0);
            checks++;
            if (Instruction_Out !== 16'd36 || PC_Out !== 16'd54 || Branch_Taken_Out !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: got %0d/%0d/%0d expected 36/54/1",
                         i, Instruction_Out, PC_Out, Branch_Taken_Out);
            end
            $display("stall[%0d]: out %0d/%0d/%0d", i, Instruction_Out, PC_Out, Branch_Taken_Out);
        end
    endtask

    // Flush/stall pulses that miss the edge must leave the outputs untouched.
    task automatic test_between_edges();
        Flush = 1'b1;
        Stall = 1'b0;
        #2;
        Flush = 1'b0;
        checks++;
        if (Instruction_Out !== 16'd36 || PC_Out !== 16'd54 || Branch_Taken_Out !== 1'b1) begin
            errors++;
            $display("FAIL mid_cycle_flush: got %0d/%0d/%0d expected 36/54/1",
                     Instruction_Out, PC_Out, Branch_Taken_Out);
        end
        Stall = 1'b1;
        $display("mid_cycle_flush: out %0d/%0d/%0d", Instruction_Out, PC_Out, Branch_Taken_Out);
    endtask

    task automatic test_flush_over_stall();
        step(1'b0, 1'b1, 1'b1, 16'd25, 16'd78, 1'b1);
        checks++;
        if (Instruction_Out !== 16'd0 || PC_Out !== 16'd0 || Branch_Taken_Out !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_stall: got %0d/%0d/%0d expected 0/0/0",
                     Instruction_Out, PC_Out, Branch_Taken_Out);
        end
`ifdef IF_ID_VALID_EN
        checks++;
        if (Valid_Out !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %0b expected 0", Valid_Out);
        end
`endif
        $display("flush_over_stall: out %0d/%0d/%0d", Instruction_Out, PC_Out, Branch_Taken_Out);
    endtask

    task automatic test_release_reset();
        step(1'b0, 1'b0, 1'b0, 16'd25, 16'd78, 1'b0);
        checks++;
        if (Instruction_Out !== 16'd25 || PC_Out !== 16'd78 || Branch_Taken_Out !== 1'b0) begin
            errors++;
            $display("FAIL release: got %0d/%0d/%0d expected 25/78/0",
                     Instruction_Out, PC_Out, Branch_Taken_Out);
        end
        $display("release: out %0d/%0d/%0d", Instruction_Out, PC_Out, Branch_Taken_Out);
        step(1'b0, 1'b0, 1'b0, 16'd99, 16'd77, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'd11, 16'd22, 1'b1);
        checks++;
        if (Instruction_Out !== 16'd0 || PC_Out !== 16'd0 || Branch_Taken_Out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %0d/%0d/%0d expected 0/0/0",
                     Instruction_Out, PC_Out, Branch_Taken_Out);
        end
        $display("reset_mid_stall: out %0d/%0d/%0d", Instruction_Out, PC_Out, Branch_Taken_Out);
    endtask

    task automatic test_back_to_back();
        logic [15:0] instrs [3] = '{16'd1, 16'd3, 16'd5};
        logic [15:0] pcs    [3] = '{16'd2, 16'd4, 16'd6};
        logic        bts    [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, instrs[i], pcs[i], bts[i]);
            checks++;
            if (Instruction_Out !== instrs[i] || PC_Out !== pcs[i] || Branch_Taken_Out !== bts[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         i, Instruction_Out, PC_Out, Branch_Taken_Out, instrs[i], pcs[i], bts[i]);
            end
            $display("back_to_back[%0d]: out %0d/%0d/%0d", i, Instruction_Out, PC_Out, Branch_Taken_Out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic rst, flush, stall;
            rst   = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 5) == 0);
            stall = ($urandom_range(0, 2) == 0);
            step(rst, flush, stall, 16'($urandom), 16'($urandom), 1'($urandom));
            checks++;
            if (Instruction_Out !== m_instr || PC_Out !== m_pc || Branch_Taken_Out !== m_bt) begin
                errors++;
                $display("FAIL random[%0d] rst=%0b flush=%0b stall=%0b: got %0h/%0h/%0b expected %0h/%0h/%0b",
                         i, rst, flush, stall, Instruction_Out, PC_Out, Branch_Taken_Out,
                         m_instr, m_pc, m_bt);
            end
`ifdef IF_ID_VALID_EN
            checks++;
            if (Valid_Out !== m_valid) begin
                errors++;
                $display("FAIL random_valid[%0d]: got %0b expected %0b", i, Valid_Out, m_valid);
            end
`endif
            $display("random[%0d]: rst=%0b flush=%0b stall=%0b out %0h/%0h/%0b",
                     i, rst, flush, stall, Instruction_Out, PC_Out, Branch_Taken_Out);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_between_edges();
        test_flush_over_stall();
        test_release_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
